// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IFU/LSU memory-port arbiter.
package mem_arb_pkg;

    // Arbiter transaction phases.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Which requester holds (or last held) the memory port.
    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_t;

    // Bit positions inside the one-hot grant vector.
    localparam int GNT_IFU = 0;
    localparam int GNT_LSU = 1;

    // Response data returned when the memory never answers.
    localparam logic [31:0] TIMEOUT_FILL = 32'hDEADBEEF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of every arbiter-facing signal: IFU port, LSU port, memory port and
// status. The arbiter uses the slave view; the surrounding core/bench drives
// the master view.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    // IFU (read-only fetch)
    logic                  ifu_req_valid;
    logic                  ifu_req_ready;
    logic [ADDR_WIDTH-1:0] ifu_req_addr;
    logic                  ifu_resp_valid;
    logic [DATA_WIDTH-1:0] ifu_resp_data;

    // LSU (load/store)
    logic                  lsu_req_valid;
    logic                  lsu_req_ready;
    logic [ADDR_WIDTH-1:0] lsu_req_addr;
    logic                  lsu_req_wen;
    logic [DATA_WIDTH-1:0] lsu_req_wdata;
    logic [MASK_WIDTH-1:0] lsu_req_wmask;
    logic                  lsu_resp_valid;
    logic [DATA_WIDTH-1:0] lsu_resp_data;

    // Shared memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_WIDTH-1:0] mem_req_addr;
    logic                  mem_req_wen;
    logic [DATA_WIDTH-1:0] mem_req_wdata;
    logic [MASK_WIDTH-1:0] mem_req_wmask;
    logic                  mem_resp_valid;
    logic [DATA_WIDTH-1:0] mem_resp_data;

    // Status
    logic                  busy;
    logic                  owner;

    modport slave (
        input  ifu_req_valid, ifu_req_addr,
        output ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        input  lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output busy, owner
    );

    modport master (
        output ifu_req_valid, ifu_req_addr,
        input  ifu_req_ready, ifu_resp_valid, ifu_resp_data,
        output lsu_req_valid, lsu_req_addr, lsu_req_wen, lsu_req_wdata, lsu_req_wmask,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  busy, owner
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Two-way round-robin picker: a lone requester always wins; under contention
// the requester that did not win last time is chosen.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic       ifu_valid,
    input  logic       lsu_valid,
    input  owner_t     owner,
    output logic [1:0] grant
);

    // Select one requester, one-hot, from the valid pair and last owner.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path through the case can leave it unassigned and infer a latch.
        grant = 2'b00;
        case ({lsu_valid, ifu_valid})
            2'b01:   grant[GNT_IFU] = 1'b1;
            2'b10:   grant[GNT_LSU] = 1'b1;
            2'b11: begin
                if (owner == OWN_IFU) grant[GNT_LSU] = 1'b1;
                else                  grant[GNT_IFU] = 1'b1;
            end
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between IFU and LSU with a single outstanding
// transaction (IDLE -> REQ -> WAIT -> IDLE), round-robin grant, and response
// routing back to the requester that issued the request.
// Optional macro MEM_ARB_TIMEOUT_EN: WAIT is bounded by TIMEOUT_CYCLES and an
// unanswered request completes with DEADBEEF fill data.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clock,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    state_t                state;
    state_t                state_next;
    owner_t                owner_q;
    logic [1:0]            grant;
    logic                  accept;
    logic                  resp_fire;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] timeout_data;
    logic [DATA_WIDTH-1:0] resp_data;

    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  wen_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [MASK_WIDTH-1:0] wmask_q;

    mem_arb_pick u_pick (
        .ifu_valid (bus.ifu_req_valid),
        .lsu_valid (bus.lsu_req_valid),
        .owner     (owner_q),
        .grant     (grant)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_RAW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int CNT_WIDTH = (CNT_RAW > 8) ? CNT_RAW : 8;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

    // Fill pattern repeated (or cut) to the data width.
    function automatic logic [DATA_WIDTH-1:0] fill_word();
        logic [DATA_WIDTH-1:0] w;
        for (int i = 0; i < DATA_WIDTH; i++) w[i] = TIMEOUT_FILL[i % 32];
        return w;
    endfunction

    logic [CNT_WIDTH-1:0] wait_cnt;

    // Count WAIT cycles without a response; held at zero outside WAIT so each
    // WAIT phase starts from a clean count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT) begin
            wait_cnt <= '0;
        end else if (!bus.mem_resp_valid && (wait_cnt != CNT_LIMIT)) begin
            wait_cnt <= wait_cnt + CNT_WIDTH'(1);
        end
    end

    assign timeout_hit  = (state == WAIT) && (wait_cnt == CNT_LIMIT);
    assign timeout_data = fill_word();
`else
    // Without the timeout WAIT simply lasts until memory answers.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout_hit        = 1'b0;
    assign timeout_data       = '0;
`endif

    // Next-state logic: grant in IDLE, hold request until accepted, wait for
    // the response (or timeout) and return to IDLE.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        resp_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                if (bus.mem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (bus.mem_resp_valid || timeout_hit) begin
                    resp_fire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples pre-edge values regardless of block ordering.
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Capture the granted request and remember who owns the transaction.
    always_ff @(posedge clock or posedge reset) begin
        // NOTE: the payload registers are reset too, because their values are
        // visible on the memory port and must read as zero out of reset.
        if (reset) begin
            owner_q <= OWN_IFU;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else if (accept) begin
            if (grant[GNT_LSU]) begin
                owner_q <= OWN_LSU;
                addr_q  <= bus.lsu_req_addr;
                wen_q   <= bus.lsu_req_wen;
                wdata_q <= bus.lsu_req_wdata;
                wmask_q <= bus.lsu_req_wmask;
            end else begin
                owner_q <= OWN_IFU;
                addr_q  <= bus.ifu_req_addr;
                wen_q   <= 1'b0;
                wdata_q <= '0;
                wmask_q <= '0;
            end
        end
    end

    // A real memory response in the same cycle beats the timeout fill.
    assign resp_data = bus.mem_resp_valid ? bus.mem_resp_data : timeout_data;

    // Requests are only taken in IDLE, and never while reset is asserted.
    assign bus.ifu_req_ready  = !reset && (state == IDLE) && grant[GNT_IFU];
    assign bus.lsu_req_ready  = !reset && (state == IDLE) && grant[GNT_LSU];

    assign bus.mem_req_valid  = (state == REQ);
    assign bus.mem_req_addr   = addr_q;
    assign bus.mem_req_wen    = wen_q;
    assign bus.mem_req_wdata  = wdata_q;
    assign bus.mem_req_wmask  = wmask_q;

    assign bus.ifu_resp_valid = resp_fire && (owner_q == OWN_IFU);
    assign bus.lsu_resp_valid = resp_fire && (owner_q == OWN_LSU);
    assign bus.ifu_resp_data  = resp_data;
    assign bus.lsu_resp_data  = resp_data;

    assign bus.busy           = (state != IDLE);
    assign bus.owner          = owner_q;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one memory port between the IFU (instruction fetch, read-only) and the LSU (load/store) as the core moves to multi-cycle memory access.
- Sits between ifu/lsu and the memory/bus model.
- Holds at most one outstanding transaction, arbitrates round-robin, and routes each response back to the requester that issued it.

Parameters:
ADDR_WIDTH, 32, address width of all request ports
DATA_WIDTH, 32, data width; mask width is DATA_WIDTH/8
TIMEOUT_CYCLES, 255, WAIT-state cycle limit (used only with MEM_ARB_TIMEOUT_EN)

Ports:
clock  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
ifu_req_valid  in  1  IFU fetch request
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_req_addr  in  ADDR_WIDTH  fetch address
ifu_resp_valid  out  1  one-cycle pulse, fetch data valid
ifu_resp_data  out  DATA_WIDTH  fetched instruction
lsu_req_valid  in  1  LSU request
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_req_addr  in  ADDR_WIDTH  load/store address
lsu_req_wen  in  1  1=store, 0=load
lsu_req_wdata  in  DATA_WIDTH  store data
lsu_req_wmask  in  DATA_WIDTH/8  store byte mask
lsu_resp_valid  out  1  one-cycle pulse, load data or store ack
lsu_resp_data  out  DATA_WIDTH  load data (store: don't-care)
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  ADDR_WIDTH  registered address
mem_req_wen  out  1  registered write enable (0 for IFU)
mem_req_wdata  out  DATA_WIDTH  registered store data
mem_req_wmask  out  DATA_WIDTH/8  registered mask (0 for IFU)
mem_resp_valid  in  1  memory response
mem_resp_data  in  DATA_WIDTH  memory read data
busy  out  1  state != IDLE
owner  out  1  0=IFU, 1=LSU; last granted requester

Behaviour:
- Reset (async, immediate): state=IDLE, all valid/ready outputs 0, mem_req_* payload 0, owner=0 (next grant prefers LSU).
- FSM IDLE -> REQ -> WAIT -> IDLE.
- IDLE:
  - If exactly one requester is valid, it is granted.
  - If both are valid, the one not equal to owner is granted (round-robin).
  - Grant is combinational: the granted *_req_ready=1 in the same cycle.
  - On the edge, capture addr/wen/wdata/wmask (IFU: wen=0, wmask=0), update owner, go to REQ.
  - The non-granted ready is 0.
- REQ: mem_req_valid=1 with registered payload, held stable until mem_req_ready=1; then go to WAIT.
- WAIT:
  - mem_resp_valid is sampled only in WAIT; responses in IDLE or REQ are ignored.
  - On mem_resp_valid=1, the owner's *_resp_valid=1 for that cycle and *_resp_data=mem_resp_data (combinational passthrough); go to IDLE.
  - The other requester's resp_valid stays 0.
- Both *_req_ready are 0 outside IDLE.
- Minimum latency: accept at T, mem_req_valid at T+1, resp_valid at T+2 (ready at T+1, response at T+2), next accept at T+3.
- Requester rules: after the handshake, a requester keeps req_valid low until its response arrives. A requester dropping valid before grant is legal; nothing is captured.
- Starvation bound: under continuous contention, grants strictly alternate.
- Reset mid-transaction: the transaction is dropped and no response is delivered. A late memory response after reset is ignored (FSM is in IDLE).

Optional Feature:
- Macro MEM_ARB_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter (width clog2(TIMEOUT_CYCLES+1)) clears on entry to WAIT and increments each WAIT cycle without mem_resp_valid.
  - When it reaches TIMEOUT_CYCLES: owner's resp_valid=1, resp_data=32'hDEADBEEF (replicated/truncated to DATA_WIDTH), go to IDLE.
  - mem_resp_valid in the same cycle wins over timeout.
- Undefined: no counter; WAIT lasts indefinitely.

Decomposition:
- Package mem_arb_pkg:
  - state encoding IDLE=2'd0, REQ=2'd1, WAIT=2'd2
  - owner encoding OWN_IFU=1'b0, OWN_LSU=1'b1
  - timeout fill constant 32'hDEADBEEF
- One sub-module, mem_arb_pick: 2-way round-robin picker (valid pair plus owner -> grant one-hot).
- FSM, payload registers, timeout counter and response routing stay in mem_arbiter.

Test Plan:
- IFU only, addr 0x80000000, mem_req_ready=1, resp 0x00000413 next cycle -> ifu_resp_valid pulse at T+2 with 0x00000413; lsu_resp_valid stays 0.
- Both valid from reset -> LSU granted first (owner reset 0), then IFU, then LSU; continuous contention alternates grants exactly.
- LSU store addr 0x80001000, wdata 0x12345678, wmask 4'b0011, mem_req_ready low 3 cycles -> mem_req_* held stable for 4 cycles; lsu_resp_valid on ack.
- Spurious mem_resp_valid in IDLE and in REQ -> no resp_valid on either side, FSM unchanged.
- Assert reset during WAIT, then mem_resp_valid one cycle after release -> outputs 0 immediately, no response pulse, next IFU request served normally.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, no memory response -> owner resp_valid with 0xDEADBEEF after 4 WAIT cycles; FSM back to IDLE.
